// File: rtl/xrisc_multi_ctrl.sv
// xrisc_multi_ctrl: multicycle X-RISC control FSM driving a shared memory port, ALU and PC/IR/OldPC/ALUOut/Data registers.
// Define XRISC_CTRL_PERF_EN to build the cycle and retired-instruction counters; otherwise both ports are tied to 0.
module xrisc_multi_ctrl #(
    parameter int unsigned STATE_W     = 4,
    parameter bit          TRAP_STICKY = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_control,
    output logic [1:0]         imm_src,
    output logic               reg_write,
    output logic               illegal,
    output logic [STATE_W-1:0] state,
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        instret_cnt
);
    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECR    = 4'd6;
    localparam logic [3:0] EXECI    = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BEQ      = 4'd9;
    localparam logic [3:0] JAL      = 4'd10;
    localparam logic [3:0] TRAP     = 4'd11;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic [3:0] st, nxt;
    logic [1:0] alu_op;
    logic [2:0] alu_f3;
    logic       bad_f3;

    always_ff @(posedge clk or negedge reset)
        if (!reset) st <= FETCH;
        else        st <= nxt;

    always_comb begin
        nxt        = FETCH;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        reg_write  = 1'b0;
        alu_op     = 2'b00;
        case (st)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                nxt        = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                nxt = (op == OP_LW || op == OP_SW) ? MEMADR :
                      (op == OP_R)   ? EXECR :
                      (op == OP_I)   ? EXECI :
                      (op == OP_BEQ) ? BEQ   :
                      (op == OP_JAL) ? JAL   : TRAP;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                nxt       = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                nxt     = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                nxt       = mem_ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                nxt       = ALUWB;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                nxt       = ALUWB;
            end
            ALUWB: reg_write = 1'b1;
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = zero;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                nxt       = ALUWB;
            end
            TRAP: nxt = TRAP_STICKY ? TRAP : FETCH;
            default: nxt = FETCH;
        endcase
    end

    always_comb begin
        bad_f3 = 1'b0;
        alu_f3 = 3'b000;
        case (funct3)
            3'b000: alu_f3 = (op[5] & funct7b5) ? 3'b001 : 3'b000;
            3'b010: alu_f3 = 3'b101;
            3'b110: alu_f3 = 3'b011;
            3'b111: alu_f3 = 3'b010;
            default: bad_f3 = 1'b1;
        endcase
    end

    assign alu_control = (alu_op == 2'b10) ? alu_f3 : (alu_op == 2'b01) ? 3'b001 : 3'b000;
    assign illegal     = (st == TRAP) | ((alu_op == 2'b10) & bad_f3);
    assign imm_src     = (op == OP_SW) ? 2'b01 : (op == OP_BEQ) ? 2'b10 : (op == OP_JAL) ? 2'b11 : 2'b00;
    assign state       = STATE_W'(st);

`ifdef XRISC_CTRL_PERF_EN
    logic [31:0] cyc_q, ret_q;
    logic        retire;

    // TRAP->FETCH is not a retirement; JAL retires through ALUWB
    assign retire = (nxt == FETCH) && (st == MEMWB || st == MEMWRITE || st == ALUWB || st == BEQ);

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (retire) ret_q <= ret_q + 32'd1;
        end

    assign cycle_cnt   = cyc_q;
    assign instret_cnt = ret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif
endmodule

// File: tb/tb_xrisc_multi_ctrl.sv
// tb_xrisc_multi_ctrl: scoreboard bench; stimulus pushes expected control vectors, a negedge monitor pops and compares.
module tb_xrisc_multi_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0]  alu_control;
    logic [3:0]  state;
    logic [31:0] cycle_cnt, instret_cnt;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, mw, irw;
        logic [1:0] rs, sa, sb;
        logic [2:0] alu;
        logic [1:0] imm;
        logic       rw, ill;
    } ctl_t;

    typedef struct {
        ctl_t  v;
        string name;
    } exp_t;

    exp_t       q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] cur_imm;

    xrisc_multi_ctrl #(.STATE_W(4), .TRAP_STICKY(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .imm_src(imm_src), .reg_write(reg_write), .illegal(illegal), .state(state),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    // Control table row for a state; the ALU code and illegal flag of EXEC states are hand-supplied per test
    function automatic ctl_t row(input int s, input logic mr, input logic z, input logic [2:0] alu, input logic ill);
        ctl_t r;
        r     = '0;
        r.st  = s[3:0];
        r.imm = cur_imm;
        case (s)
            0:  begin r.sb = 2'b10; r.rs = 2'b10; r.pcw = mr; r.irw = mr; end
            1:  begin r.sa = 2'b01; r.sb = 2'b01; end
            2:  begin r.sa = 2'b10; r.sb = 2'b01; end
            3:  r.adr = 1'b1;
            4:  begin r.rs = 2'b01; r.rw = 1'b1; end
            5:  begin r.adr = 1'b1; r.mw = 1'b1; end
            6:  begin r.sa = 2'b10; r.alu = alu; r.ill = ill; end
            7:  begin r.sa = 2'b10; r.sb = 2'b01; r.alu = alu; r.ill = ill; end
            8:  r.rw = 1'b1;
            9:  begin r.sa = 2'b10; r.alu = 3'b001; r.pcw = z; end
            10: begin r.sa = 2'b01; r.sb = 2'b10; r.pcw = 1'b1; end
            11: r.ill = 1'b1;
            default: ;
        endcase
        return r;
    endfunction

    task automatic ins(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic [1:0] imm);
        op = o; funct3 = f3; funct7b5 = f7; cur_imm = imm;
    endtask

    task automatic cyc(input int s, input logic mr, input logic z, input logic [2:0] alu, input logic ill, input string name);
        mem_ready = mr;
        zero      = z;
        q.push_back('{row(s, mr, z, alu, ill), name});
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            ctl_t a;
            e = q.pop_front();
            a = '{state, pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                  alu_control, imm_src, reg_write, illegal};
            n_cmp++;
            if (a !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h want %h (state got %0d want %0d)", e.name, a, e.v, a.st, e.v.st);
            end
        end
    end

`ifdef XRISC_CTRL_PERF_EN
    localparam logic [31:0] EXP_CYC = 32'd12;
    localparam logic [31:0] EXP_RET = 32'd3;
`else
    localparam logic [31:0] EXP_CYC = 32'd0;
    localparam logic [31:0] EXP_RET = 32'd0;
`endif

    initial begin
        reset = 1'b0;
        mem_ready = 1'b0;
        zero = 1'b0;
        ins(7'b0010011, 3'b000, 1'b0, 2'b00);
        q.push_back('{row(0, 1'b0, 1'b0, 3'b000, 1'b0), "reset"});
        @(posedge clk); #1;
        chk32("cycle_cnt_in_reset", cycle_cnt, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        // three back-to-back addi: 12 clocks, 3 retirements
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1'b1, 1'b0, 3'b000, 1'b0, "addi_fetch");
            cyc(1, 1'b1, 1'b0, 3'b000, 1'b0, "addi_decode");
            cyc(7, 1'b1, 1'b0, 3'b000, 1'b0, "addi_execi");
            cyc(8, 1'b1, 1'b0, 3'b000, 1'b0, "addi_aluwb");
        end
        chk32("cycle_cnt_12", cycle_cnt, EXP_CYC);
        chk32("instret_cnt_3", instret_cnt, EXP_RET);
        ins(7'b0000011, 3'b010, 1'b0, 2'b00);
        cyc(0, 1'b1, 1'b0, 3'b000, 1'b0, "lw_fetch");
        cyc(1, 1'b1, 1'b0, 3'b000, 1'b0, "lw_decode");
        cyc(2, 1'b1, 1'b0, 3'b000, 1'b0, "lw_memadr");
        cyc(3, 1'b1, 1'b0, 3'b000, 1'b0, "lw_memread");
        cyc(4, 1'b1, 1'b0, 3'b000, 1'b0, "lw_memwb");
        ins(7'b0100011, 3'b010, 1'b0, 2'b01);
        cyc(0, 1'b1, 1'b0, 3'b000, 1'b0, "sw_fetch");
        cyc(1, 1'b1, 1'b0, 3'b000, 1'b0, "sw_decode");
        cyc(2, 1'b1, 1'b0, 3'b000, 1'b0, "sw_memadr");
        cyc(5, 1'b0, 1'b0, 3'b000, 1'b0, "sw_memwrite_wait1");
        cyc(5, 1'b0, 1'b0, 3'b000, 1'b0, "sw_memwrite_wait2");
        cyc(5, 1'b1, 1'b0, 3'b000, 1'b0, "sw_memwrite_done");
        ins(7'b0110011, 3'b000, 1'b1, 2'b00);
        cyc(0, 1'b1, 1'b0, 3'b000, 1'b0, "sub_fetch");
        cyc(1, 1'b1, 1'b0, 3'b000, 1'b0, "sub_decode");
        cyc(6, 1'b1, 1'b0, 3'b001, 1'b0, "sub_execr");
        cyc(8, 1'b1, 1'b0, 3'b000, 1'b0, "sub_aluwb");
        // funct7b5 set on an I-type must still add (op[5]=0)
        ins(7'b0010011, 3'b000, 1'b1, 2'b00);
        cyc(0, 1'b1, 1'b0, 3'b000, 1'b0, "addi7_fetch");
        cyc(1, 1'b1, 1'b0, 3'b000, 1'b0, "addi7_decode");
        cyc(7, 1'b1, 1'b0, 3'b000, 1'b0, "addi7_execi");
        cyc(8, 1'b1, 1'b0, 3'b000, 1'b0, "addi7_aluwb");
        ins(7'b0110011, 3'b110, 1'b0, 2'b00);
        cyc(0, 1'b1, 1'b0, 3'b000, 1'b0, "or_fetch");
        cyc(1, 1'b1, 1'b0, 3'b000, 1'b0, "or_decode");
        cyc(6, 1'b1, 1'b0, 3'b011, 1'b0, "or_execr");
        cyc(8, 1'b1, 1'b0, 3'b000, 1'b0, "or_aluwb");
        ins(7'b0010011, 3'b010, 1'b0, 2'b00);
        cyc(0, 1'b1, 1'b0, 3'b000, 1'b0, "slti_fetch");
        cyc(1, 1'b1, 1'b0, 3'b000, 1'b0, "slti_decode");
        cyc(7, 1'b1, 1'b0, 3'b101, 1'b0, "slti_execi");
        cyc(8, 1'b1, 1'b0, 3'b000, 1'b0, "slti_aluwb");
        ins(7'b0110011, 3'b111, 1'b0, 2'b00);
        cyc(0, 1'b1, 1'b0, 3'b000, 1'b0, "and_fetch");
        cyc(1, 1'b1, 1'b0, 3'b000, 1'b0, "and_decode");
        cyc(6, 1'b1, 1'b0, 3'b010, 1'b0, "and_execr");
        cyc(8, 1'b1, 1'b0, 3'b000, 1'b0, "and_aluwb");
        ins(7'b0110011, 3'b001, 1'b0, 2'b00);
        cyc(0, 1'b1, 1'b0, 3'b000, 1'b0, "badf3_fetch");
        cyc(1, 1'b1, 1'b0, 3'b000, 1'b0, "badf3_decode");
        cyc(6, 1'b1, 1'b0, 3'b000, 1'b1, "badf3_execr_illegal");
        cyc(8, 1'b1, 1'b0, 3'b000, 1'b0, "badf3_aluwb");
        ins(7'b1100011, 3'b000, 1'b0, 2'b10);
        cyc(0, 1'b1, 1'b1, 3'b000, 1'b0, "beq1_fetch");
        cyc(1, 1'b1, 1'b1, 3'b000, 1'b0, "beq1_decode");
        cyc(9, 1'b1, 1'b1, 3'b000, 1'b0, "beq_taken");
        cyc(0, 1'b1, 1'b0, 3'b000, 1'b0, "beq0_fetch");
        cyc(1, 1'b1, 1'b0, 3'b000, 1'b0, "beq0_decode");
        cyc(9, 1'b1, 1'b0, 3'b000, 1'b0, "beq_not_taken");
        ins(7'b1101111, 3'b000, 1'b0, 2'b11);
        cyc(0, 1'b0, 1'b0, 3'b000, 1'b0, "jal_fetch_stall");
        cyc(0, 1'b1, 1'b0, 3'b000, 1'b0, "jal_fetch");
        cyc(1, 1'b1, 1'b0, 3'b000, 1'b0, "jal_decode");
        cyc(10, 1'b1, 1'b0, 3'b000, 1'b0, "jal_jal");
        cyc(8, 1'b1, 1'b0, 3'b000, 1'b0, "jal_aluwb");
        ins(7'b0000011, 3'b010, 1'b0, 2'b00);
        cyc(0, 1'b1, 1'b0, 3'b000, 1'b0, "lws_fetch");
        cyc(1, 1'b1, 1'b0, 3'b000, 1'b0, "lws_decode");
        cyc(2, 1'b1, 1'b0, 3'b000, 1'b0, "lws_memadr");
        cyc(3, 1'b0, 1'b0, 3'b000, 1'b0, "lws_memread_wait");
        cyc(3, 1'b1, 1'b0, 3'b000, 1'b0, "lws_memread_done");
        cyc(4, 1'b1, 1'b0, 3'b000, 1'b0, "lws_memwb");
        ins(7'b1111111, 3'b000, 1'b0, 2'b00);
        cyc(0, 1'b1, 1'b0, 3'b000, 1'b0, "trap_fetch");
        cyc(1, 1'b1, 1'b0, 3'b000, 1'b0, "trap_decode");
        cyc(11, 1'b1, 1'b0, 3'b000, 1'b0, "trap_enter");
        cyc(11, 1'b1, 1'b0, 3'b000, 1'b0, "trap_sticky1");
        cyc(11, 1'b1, 1'b0, 3'b000, 1'b0, "trap_sticky2");
        // asynchronous reset mid-TRAP, observed before the next rising edge
        #1;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (state !== 4'd0 || illegal !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: got state %0d illegal %0b want state 0 illegal 0", state, illegal);
        end
        q.push_back('{row(0, 1'b1, 1'b0, 3'b000, 1'b0), "async_reset_trap"});
        @(posedge clk); #1;
        chk32("cycle_cnt_cleared", cycle_cnt, 32'd0);
        chk32("instret_cnt_cleared", instret_cnt, 32'd0);
        reset = 1'b1;
        ins(7'b0010011, 3'b000, 1'b0, 2'b00);
        cyc(0, 1'b1, 1'b0, 3'b000, 1'b0, "post_reset_fetch");
        cyc(1, 1'b1, 1'b0, 3'b000, 1'b0, "post_reset_decode");
        repeat (3) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
